// File: rtl/booth_ctrl_fsm.sv
// booth_ctrl_fsm: radix-2 Booth multiplier control (start_i/q0_i/qm1_i/count_i in; counter ld/decr, datapath strobes, addsub, busy/done out)
module booth_ctrl_fsm #(
  parameter int N_BITS = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             q0_i,
  input  logic             qm1_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             ld_o,
  output logic             decr_o,
  output logic             ld_m_o,
  output logic             ld_q_o,
  output logic             clr_a_o,
  output logic             clr_qm1_o,
  output logic             ld_a_o,
  output logic             addsub_o,
  output logic             shift_o,
  output logic             busy_o,
  output logic             done_o
);
  if (N_BITS < 1 || N_BITS >= (1 << CNT_W)) begin : g_bad_cfg
    $error("count width cannot hold N_BITS");
  end
  typedef enum logic [2:0] {IDLE, LOAD, EXAM, OP, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = start_i ? LOAD : IDLE;
      LOAD:    state_d = EXAM;
      EXAM:    state_d = (q0_i ^ qm1_i) ? OP : SHIFT;
      OP:      state_d = SHIFT;
      SHIFT:   state_d = (count_i == '0) ? DONE : EXAM;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ld_o      <= 1'b0;
      decr_o    <= 1'b0;
      ld_m_o    <= 1'b0;
      ld_q_o    <= 1'b0;
      clr_a_o   <= 1'b0;
      clr_qm1_o <= 1'b0;
      ld_a_o    <= 1'b0;
      addsub_o  <= 1'b0;
      shift_o   <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_o      <= state_d == LOAD;
      ld_m_o    <= state_d == LOAD;
      ld_q_o    <= state_d == LOAD;
      clr_a_o   <= state_d == LOAD;
      clr_qm1_o <= state_d == LOAD;
      ld_a_o    <= state_d == OP;
      shift_o   <= state_d == SHIFT;
      decr_o    <= state_d == SHIFT;
      busy_o    <= state_d != IDLE;
      done_o    <= state_d == DONE;
      if (state_q == EXAM && state_d == OP) addsub_o <= q0_i;
    end
  end
endmodule

// File: tb/tb_booth_ctrl_fsm.sv
// tb_booth_ctrl_fsm: checks the Booth control FSM against product/latency rules using counter and datapath models
module tb_booth_ctrl_fsm;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic q0, qm1;
  logic [4:0] count = 5'd0;
  logic ld, decr, ld_m, ld_q, clr_a, clr_qm1, ld_a, addsub, shift, busy, done;
  logic [15:0] a_r = '0, q_r = '0, m_r = '0, mplier = '0, mcand = '0;
  logic qm1_r = 1'b0;
  logic [10:0] outs;
  int errs = 0, checks = 0;
  typedef struct {
    logic [15:0] q;
    logic [15:0] m;
    logic [31:0] prod;
    int lat;
  } vec_t;
  vec_t vt[4];
  always #5 clk = ~clk;
  booth_ctrl_fsm dut (
    .clk(clk), .rst(rst), .start_i(start), .q0_i(q0), .qm1_i(qm1), .count_i(count),
    .ld_o(ld), .decr_o(decr), .ld_m_o(ld_m), .ld_q_o(ld_q), .clr_a_o(clr_a),
    .clr_qm1_o(clr_qm1), .ld_a_o(ld_a), .addsub_o(addsub), .shift_o(shift),
    .busy_o(busy), .done_o(done)
  );
  assign q0 = q_r[0];
  assign qm1 = qm1_r;
  assign outs = {ld, decr, ld_m, ld_q, clr_a, clr_qm1, ld_a, addsub, shift, busy, done};
  always @(negedge clk) begin
    if (ld) count <= 5'd16;
    else if (decr) count <= count - 5'd1;
  end
  always @(posedge clk) begin
    if (ld_q) q_r <= mplier;
    if (ld_m) m_r <= mcand;
    if (clr_a) a_r <= '0;
    if (clr_qm1) qm1_r <= 1'b0;
    if (ld_a) a_r <= addsub ? a_r - m_r : a_r + m_r;
    if (shift) begin
      a_r <= {a_r[15], a_r[15:1]};
      q_r <= {a_r[0], q_r[15:1]};
      qm1_r <= q_r[0];
    end
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic int ref_ops(input logic [15:0] q);
    int n = 0;
    for (int i = 0; i < 16; i++) if (q[i] != ((i == 0) ? 1'b0 : q[i-1])) n++;
    return n;
  endfunction
  function automatic logic [31:0] ref_prod(input logic [15:0] q, input logic [15:0] m);
    int p;
    p = int'($signed(q)) * int'($signed(m));
    return p;
  endfunction
  task automatic run_op(input logic [15:0] q, input logic [15:0] m, input bit noise,
                        input logic [31:0] exp_prod, input int exp_lat);
    int cyc, nld, nsh, nop;
    mplier = q;
    mcand = m;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1; nld = 0; nsh = 0; nop = 0;
    while (!done && cyc < 200) begin
      if (ld) nld++;
      if (ld_a) begin
        chk("addsub", {31'd0, addsub}, {31'd0, mplier[nsh]});
        nop++;
      end
      if (shift) nsh++;
      if (noise) start = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1 cyc++;
    end
    start = 1'b0;
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("busy_in_done", {31'd0, busy}, 32'd1);
    chk("product", {a_r, q_r}, exp_prod);
    chk("latency", cyc, exp_lat);
    chk("shifts", nsh, 16);
    chk("loads", nld, 1);
    chk("ops", nop, ref_ops(q));
    @(posedge clk);
    #1 chk("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask
  initial begin
    int n, guard, nd, nld, cyc;
    int ld_c[2], dn_c[2];
    logic [15:0] rq, rm;
    vt[0] = '{16'h0000, 16'h1234, 32'h0000_0000, 34};
    vt[1] = '{16'h0001, 16'h0003, 32'h0000_0003, 36};
    vt[2] = '{16'h5555, 16'hFFFF, 32'hFFFF_AAAB, 50};
    vt[3] = '{16'hFFFF, 16'h0002, 32'hFFFF_FFFE, 35};
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", {21'd0, outs}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("idle_outputs", {21'd0, outs}, 32'd0);
    for (int i = 0; i < 4; i++) run_op(vt[i].q, vt[i].m, 1'b0, vt[i].prod, vt[i].lat);
    for (int i = 0; i < 8; i++) begin
      rq = 16'($urandom);
      rm = 16'($urandom);
      run_op(rq, rm, 1'b1, ref_prod(rq, rm), 34 + ref_ops(rq));
    end
    mplier = 16'h5A5A;
    mcand = 16'h0777;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; guard = 0;
    while (!(shift && n == 6) && guard < 200) begin
      if (shift) n++;
      @(posedge clk);
      #1 guard++;
    end
    chk("reached_7th_shift", {31'd0, shift}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_outputs", {21'd0, outs}, 32'd0);
    nd = 0;
    repeat (40) begin
      if (done || busy) nd++;
      @(posedge clk);
      #1;
    end
    chk("no_activity_after_abort", nd, 0);
    run_op(16'h5A5A, 16'h0777, 1'b0, ref_prod(16'h5A5A, 16'h0777), 34 + ref_ops(16'h5A5A));
    mplier = vt[1].q;
    mcand = vt[1].m;
    start = 1'b1;
    @(posedge clk);
    #1 cyc = 1;
    nd = 0; nld = 0;
    ld_c = '{0, 0};
    dn_c = '{0, 0};
    while (nd < 2 && cyc < 300) begin
      if (ld) begin
        if (nld < 2) ld_c[nld] = cyc;
        nld++;
      end
      if (done) begin
        dn_c[nd] = cyc;
        chk("hold_product", {a_r, q_r}, vt[1].prod);
        nd++;
      end
      if (nd < 2) begin
        @(posedge clk);
        #1 cyc++;
      end
    end
    start = 1'b0;
    chk("hold_dones", nd, 2);
    chk("hold_loads", nld, 2);
    chk("hold_first_ld", ld_c[0], 1);
    chk("hold_first_done", dn_c[0], vt[1].lat);
    chk("hold_back_to_back", ld_c[1], dn_c[0] + 2);
    chk("hold_second_done", dn_c[1], ld_c[1] + vt[1].lat - 1);
    @(posedge clk);
    #1 chk("hold_idle_after", {30'd0, busy, done}, 32'd0);
    @(posedge clk);
    #1 chk("hold_no_restart", {31'd0, ld}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
